// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] PC_INC       = 32'd4;

  // One buffered fetch result as presented to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between instruction memory and decode.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t ent0, ent1;

  // Storage and occupancy; flush empties but may take a same-cycle push
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else if (flush) begin
      count <= push ? 2'd1 : 2'd0;
      if (push) ent0 <= din;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

endmodule

// File: rtl/instruction_fetch.sv
// PC generation and fetch stage feeding decode through a 2-entry skid FIFO.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects produce a
// flagged NOP entry (out_misalign) and halt fetch until the next redirect.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int          IM_ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     im_ce,
  output logic [IM_ADDR_WIDTH-1:0] im_addr,
  input  logic [31:0]              im_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                     out_misalign
`endif
);

  logic [31:0]  pc, req_pc, redir_tgt;
  logic         req_valid, redir_mis, halted, redirect, push, pop;
  logic [1:0]   count;
  logic [2:0]   occ;
  fetch_entry_t head, push_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_tgt = redirect_pc;
  assign redir_mis = |redirect_pc[1:0];

  // Misaligned redirect parks fetch until a later redirect or reset
  always_ff @(posedge clk) begin
    if (reset)               halted <= 1'b0;
    else if (redirect_valid) halted <= redir_mis;
  end

  assign out_misalign = reset ? 1'b0 : head.misalign;
`else
  logic [1:0] unused_redir_lsb;
  logic       unused_misalign;
  assign redir_tgt        = {redirect_pc[31:2], 2'b00};
  assign redir_mis        = 1'b0;
  assign halted           = 1'b0;
  assign unused_redir_lsb = redirect_pc[1:0];
  assign unused_misalign  = head.misalign;
`endif

  // Reset beats redirect; a redirect cycle never hands anything to decode
  assign redirect  = ~reset & redirect_valid;
  assign out_valid = ~reset & ~redirect_valid & (count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Entries that will be held after this edge if nothing new is issued
  assign occ   = {1'b0, count} + {2'b00, req_valid} - {2'b00, pop};
  assign im_ce = ~reset & (redirect_valid ? ~redir_mis : (~halted & (occ < 3'd2)));

  assign im_addr = reset          ? '0 :
                   redirect_valid ? redir_tgt[IM_ADDR_WIDTH+1:2] :
                                    pc[IM_ADDR_WIDTH+1:2];

  // The response for last cycle's request lands now unless a redirect kills it
  assign push      = redirect ? redir_mis : req_valid;
  assign push_data = redirect ? '{pc: redir_tgt, instr: NOP_INSTR, misalign: 1'b1}
                              : '{pc: req_pc,    instr: im_q,      misalign: 1'b0};

  // PC and outstanding-request tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
    end else if (redirect_valid) begin
      req_pc    <= redir_tgt;
      req_valid <= ~redir_mis;
      pc        <= redir_tgt + PC_INC;
    end else if (im_ce) begin
      req_pc    <= pc;
      req_valid <= 1'b1;
      pc        <= pc + PC_INC;
    end else begin
      req_valid <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_data),
    .count (count),
    .head  (head)
  );

  assign out_pc    = reset ? 32'd0 : head.pc;
  assign out_instr = reset ? 32'd0 : head.instr;

endmodule
